// File: rtl/faulty_fifo_pkg.sv
// faulty_fifo_pkg
//   Shared constants for the faulty_fifo block: default word width, default
//   depth and the pointer-width helper used by the top level.
package faulty_fifo_pkg;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;

    // One extra MSB beyond the address bits distinguishes full from empty
    // when the read and write addresses coincide.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/faulty_fifo_rst_busy.sv
// faulty_fifo_rst_busy
//   Post-reset busy generator. Holds busy_o high from reset assertion until
//   RST_BUSY_CYCLES rising edges after reset release.
// Ports:
//   clk      - clock, rising edge
//   reset_ni - asynchronous active-low reset
//   busy_o   - high while the FIFO must ignore read/write requests
module faulty_fifo_rst_busy
#(
    parameter int RST_BUSY_CYCLES = 4
)(
    input  logic clk,
    input  logic reset_ni,
    output logic busy_o
);
    import faulty_fifo_pkg::*;

    localparam int CW = $clog2(RST_BUSY_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Counter is parked at the full count during reset, so the first edge
    // after release already moves it to RST_BUSY_CYCLES-1.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= CW'(RST_BUSY_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign busy_o = (r_cnt != '0);

endmodule

// File: rtl/faulty_fifo.sv
// faulty_fifo
//   Single-clock FIFO with registered (1-cycle latency) read data, a
//   vendor-style reset-busy window and optional read-data corruption.
// Ports:
//   clk         - clock, rising edge
//   reset_ni    - asynchronous active-low reset
//   din_i       - write data
//   wr_en_i     - write request
//   rd_en_i     - read request
//   dout_o      - registered read data, updates only on an accepted read
//   empty_o     - registered empty flag
//   wr_rst_busy - write side still in post-reset busy window
//   rd_rst_busy - read side still in post-reset busy window
module faulty_fifo
#(
    parameter int                          DATA_W          = faulty_fifo_pkg::DATA_W,
    parameter int                          DEPTH           = faulty_fifo_pkg::DEPTH,
    parameter int                          RST_BUSY_CYCLES = 4,
    parameter bit                          FAULT_EN        = 1'b0,
    parameter logic [DATA_W-1:0]           FAULT_MASK      = DATA_W'(1)
)(
    input  logic              clk,
    input  logic              reset_ni,
    input  logic [DATA_W-1:0] din_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              wr_rst_busy,
    output logic              rd_rst_busy
);
    import faulty_fifo_pkg::*;

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    // Folded at elaboration so the read path is a plain XOR with a constant.
    localparam logic [DATA_W-1:0] L_MASK = FAULT_EN ? FAULT_MASK : '0;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [DATA_W-1:0] r_dout;
    logic              r_empty;

    logic              w_busy;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;

    faulty_fifo_rst_busy #(
        .RST_BUSY_CYCLES (RST_BUSY_CYCLES)
    ) u_rst_busy (
        .clk      (clk),
        .reset_ni (reset_ni),
        .busy_o   (w_busy)
    );

    assign w_full = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW]     != r_rd_ptr[AW]);

    // A write into a full FIFO is still accepted when a read frees the slot
    // on the same edge; the old word is read before it is overwritten.
    assign w_rd_acc = rd_en_i && !w_busy && !r_empty;
    assign w_wr_acc = wr_en_i && !w_busy && (!w_full || w_rd_acc);

    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_empty  <= 1'b1;
            r_dout   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr[AW-1:0]] ^ L_MASK;
            end
        end
    end

    // Storage has no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din_i;
        end
    end

    assign dout_o      = r_dout;
    assign empty_o     = r_empty;
    assign wr_rst_busy = w_busy;
    assign rd_rst_busy = w_busy;

endmodule

// File: tb/tb_faulty_fifo.sv
module tb_faulty_fifo;
    localparam int DW = 64;
    localparam int DP = 16;

    logic          clk      = 1'b0;
    logic          reset_ni = 1'b0;
    logic [DW-1:0] din      = '0;
    logic          wr_en    = 1'b0;
    logic          rd_en    = 1'b0;

    logic [DW-1:0] dout, f_dout;
    logic          empty, wr_busy, rd_busy;
    logic          f_empty, f_wr_busy, f_rd_busy;

    always #5 clk = ~clk;

    faulty_fifo dut (
        .clk         (clk),
        .reset_ni    (reset_ni),
        .din_i       (din),
        .wr_en_i     (wr_en),
        .rd_en_i     (rd_en),
        .dout_o      (dout),
        .empty_o     (empty),
        .wr_rst_busy (wr_busy),
        .rd_rst_busy (rd_busy)
    );

    // Same stimulus, corruption enabled with mask 1.
    faulty_fifo #(
        .FAULT_EN   (1'b1),
        .FAULT_MASK (64'h1)
    ) dut_f (
        .clk         (clk),
        .reset_ni    (reset_ni),
        .din_i       (din),
        .wr_en_i     (wr_en),
        .rd_en_i     (rd_en),
        .dout_o      (f_dout),
        .empty_o     (f_empty),
        .wr_rst_busy (f_wr_busy),
        .rd_rst_busy (f_rd_busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] exp_q[$];
    bit            ready = 1'b0;
    logic [DW-1:0] last  = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; called at a negedge, returns at the next negedge.
    task automatic cycle(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit            racc, wacc;
        logic [DW-1:0] e;
        din = d; wr_en = wr; rd_en = rd;
        racc = ready && rd && (mdl.size() > 0);
        wacc = ready && wr && ((mdl.size() < DP) || racc);
        if (racc) exp_q.push_back(mdl.pop_front());
        if (wacc) mdl.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        if (racc) begin
            e = exp_q.pop_front();
            chk("rd_data", dout, e);
            chk("rd_data_fault", f_dout, e ^ 64'h1);
            last = e;
        end else begin
            chk("dout_hold", dout, last);
        end
        chk("empty", {63'b0, empty}, {63'b0, mdl.size() == 0});
        chk("empty_fault", {63'b0, f_empty}, {63'b0, mdl.size() == 0});
    endtask

    typedef struct {
        bit            wr;
        bit            rd;
        logic [DW-1:0] din;
        bit            exp_empty;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;

        // Reset held 10 cycles: busy high, empty high, dout zero.
        reset_ni = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_busy", {62'b0, wr_busy, rd_busy}, 64'h3);
            chk("rst_empty", {63'b0, empty}, 64'h1);
            chk("rst_dout", dout, 64'h0);
        end

        // Release; hold wr_en through the busy window to prove it is ignored.
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        wr_en = 1'b1; din = 64'hDEAD_BEEF_0000_0001;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) wr_en = 1'b0;
            @(negedge clk);
            chk($sformatf("busy_edge%0d", k), {62'b0, wr_busy, rd_busy}, (k < 4) ? 64'h3 : 64'h0);
            chk("busy_fault", {63'b0, f_wr_busy & f_rd_busy}, (k < 4) ? 64'h1 : 64'h0);
            chk("busy_empty", {63'b0, empty}, 64'h1);
            chk("busy_dout", dout, 64'h0);
        end
        ready = 1'b1;

        // Table: single word, read on empty, simultaneous access on empty.
        tbl[0] = '{1'b1, 1'b0, 64'hABABABABABABABAB, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 1'b0, 64'h0,                1'b0, 64'h0};
        tbl[2] = '{1'b0, 1'b1, 64'h0,                1'b1, 64'hABABABABABABABAB};
        tbl[3] = '{1'b0, 1'b1, 64'h0,                1'b1, 64'hABABABABABABABAB};
        tbl[4] = '{1'b1, 1'b1, 64'h55,               1'b0, 64'hABABABABABABABAB};
        tbl[5] = '{1'b0, 1'b1, 64'h0,                1'b1, 64'h55};
        for (int i = 0; i < 6; i++) begin
            din = tbl[i].din; wr_en = tbl[i].wr; rd_en = tbl[i].rd;
            @(posedge clk);
            #1;
            wr_en = 1'b0; rd_en = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_empty", i), {63'b0, empty}, {63'b0, tbl[i].exp_empty});
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
        end
        chk("tbl_fault_dout", f_dout, 64'h54);
        last = 64'h55;

        // Fill with 0..16; the 17th write is dropped.
        for (int i = 0; i <= 16; i++) cycle(1'b1, 1'b0, 64'(i));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        chk("fill_last", dout, 64'd15);
        cycle(1'b0, 1'b1, '0);

        // Simultaneous read/write while full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
        cycle(1'b1, 1'b1, 64'hF0F0_0000_1234_5678);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);

        // Half full, 40 cycles of simultaneous access across pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);

        // Fault injection: 0x10 reads back as 0x11 on the corrupting instance.
        cycle(1'b1, 1'b0, 64'h10);
        cycle(1'b0, 1'b1, '0);
        chk("fault_dout", f_dout, 64'h11);
        chk("clean_dout", dout, 64'h10);

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h100 + 64'(i));
        #2;
        reset_ni = 1'b0;
        #1;
        chk("midrst_empty", {63'b0, empty}, 64'h1);
        chk("midrst_busy", {62'b0, wr_busy, rd_busy}, 64'h3);
        chk("midrst_dout", dout, 64'h0);
        mdl.delete(); exp_q.delete();
        ready = 1'b0; last = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        n = 0;
        while (wr_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_busy_clear", {62'b0, wr_busy, rd_busy}, 64'h0);
        chk("midrst_busy_len", 64'(n), 64'd5);
        ready = 1'b1;
        cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 64'h77);
        cycle(1'b0, 1'b1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/faulty_fifo.md
# faulty_fifo

Single-clock, synchronous-read FIFO buffering 64-bit words between a producer and a consumer in one clock domain. It models a vendor FIFO primitive: it reports reset-busy status after reset and can corrupt read data under parameter control. Testbenches use that corruption to confirm that downstream checkers catch data errors. With fault injection disabled it is a plain, lossless FIFO.

## Interface
Parameters:
- DATA_W, 64: word width in bits.
- DEPTH, 16: number of entries; must be a power of two and at least 2.
- RST_BUSY_CYCLES, 4: number of clock cycles the busy flags stay high after reset deassertion; must be at least 1.
- FAULT_EN, 0: 1 enables read-data corruption.
- FAULT_MASK, 64'h0000_0000_0000_0001: XOR mask applied to read data when FAULT_EN=1.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: the single clock; all logic is rising-edge.
- reset_ni, input, 1: asynchronous active-low reset.
- din_i, input, DATA_W: write data.
- wr_en_i, input, 1: write request.
- rd_en_i, input, 1: read request.
- dout_o, output, DATA_W: registered read data.
- empty_o, output, 1: FIFO holds no words.
- wr_rst_busy, output, 1: write side is not yet accepting writes.
- rd_rst_busy, output, 1: read side is not yet accepting reads.

## Operation
- Reset asserted:
  - Pointers, occupancy and dout_o clear to 0.
  - empty_o=1, wr_rst_busy=1, rd_rst_busy=1.
  - Memory contents are not reset.
- Busy counter:
  - Starts at RST_BUSY_CYCLES when reset releases and decrements by 1 per clk edge.
  - Both busy flags drop together when it reaches 0.
- While busy, wr_en_i and rd_en_i are ignored.
- Write accept: wr_en_i=1 and not busy and not full. Accepted data is stored at the write pointer, and the pointer advances.
- Write while full: dropped silently. No state changes.
- Read accept: rd_en_i=1 and not busy and not empty. The word at the read pointer is loaded into dout_o, and the pointer advances.
- Read while empty: ignored. dout_o holds its value.
- dout_o changes only on an accepted read.
- Corruption: when FAULT_EN=1, every accepted read loads mem XOR FAULT_MASK. When FAULT_EN=0, data passes through unmodified.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - empty: pointers are equal.
  - full: address bits are equal and the MSBs differ.
- Simultaneous read and write:
  - Not empty and not full: both accepted; occupancy unchanged.
  - Empty: only the write is accepted.
  - Full: both accepted, since the read frees the slot in the same edge.

## Timing
- After reset release, the first write can be accepted on edge RST_BUSY_CYCLES+1.
- empty_o is registered.
  - It deasserts on the clk edge that accepts the first write, so the word is readable from the following cycle.
  - It asserts on the edge that accepts the read of the last word.
- Read latency is 1 cycle: dout_o is valid after the edge that accepts rd_en_i. There is no first-word-fall-through.
- Reset asserted mid-operation takes effect immediately. All stored words are discarded, and the busy sequence restarts on release.

## Structure
- Constants DATA_W and DEPTH, and the pointer-width function, belong in a shared package faulty_fifo_pkg.
- The reset-busy counter is the one natural sub-module: faulty_fifo_rst_busy.
  - Inputs: clk, reset_ni.
  - Output: a busy flag, fanned out to both busy ports.
- Storage is an inferred register array in the top level.

## Test plan
- Reset sequence:
  - Stimulus: hold reset_ni=0 for 10 cycles, then release.
  - Response: both busy flags stay at 1 for exactly 4 cycles and then fall; empty_o=1 and dout_o=0 throughout.
- Single word:
  - Stimulus: after busy clears, write 64'hABABABABABABABAB for one cycle.
  - Response: empty_o=0 on the next cycle. After that, rd_en_i for one cycle gives dout_o=64'hABABABABABABABAB and then empty_o=1.
- Fill and overflow:
  - Stimulus: write values 0..16 on consecutive cycles.
  - Response: the 17th write is dropped. Reading 16 words returns 0..15 in order, and empty_o=1 after the last read.
- Wrap and simultaneous access:
  - Stimulus: keep the FIFO half full while writing and reading together every cycle for 40 cycles.
  - Response: data stays in order, with no loss across pointer wrap; empty_o stays 0.
- Fault injection:
  - Stimulus: set FAULT_EN=1 and FAULT_MASK=64'h1, then write 64'h10 and read it.
  - Response: dout_o=64'h11.
- Reset mid-operation:
  - Stimulus: write 3 words, assert reset_ni=0, then release.
  - Response: empty_o=1 and both busy flags are high; after busy clears, reads return nothing.
